// File: rtl/circuit_sweep_ctrl.sv
// Exhaustive 0..31 sweep sequencer for the 5-in/5-out circuit block, folding responses into a 16-bit MISR.
// Optional golden-signature comparator (exp_sig/pass) is built only when CIRCUIT_SWEEP_CMP_EN is defined.
module circuit_sweep_ctrl #(
    parameter int          SETTLE = 1,
    parameter logic [15:0] SEED   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  dut_out,
    output logic [4:0]  dut_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] sig
`ifdef CIRCUIT_SWEEP_CMP_EN
    ,
    input  logic [15:0] exp_sig,
    output logic        pass
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [4:0] VEC_LAST  = 5'd31;

    // MISR taps 15,14,12,3 shifted in at bit 0, response XORed into the low five bits
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [4:0] d);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb} ^ {11'b0, d};
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_vec;
    logic [4:0]  w_vec_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [15:0] r_sig;
    logic [15:0] w_sig_next;
    logic [4:0]  r_dut_in;
    logic [4:0]  w_dut_in_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        r_done;
    logic        w_done_next;
    logic        w_start_acc;
    logic        w_abort_acc;
    logic        w_finish;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_vec    <= 5'd0;
            r_cnt    <= 4'd0;
            r_sig    <= SEED;
            r_dut_in <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_vec    <= w_vec_next;
            r_cnt    <= w_cnt_next;
            r_sig    <= w_sig_next;
            r_dut_in <= w_dut_in_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    // Next-state, datapath update and look-ahead of the registered outputs
    always_comb begin
        w_state_next = r_state;
        w_vec_next   = r_vec;
        w_cnt_next   = r_cnt;
        w_sig_next   = r_sig;
        w_start_acc  = 1'b0;
        w_abort_acc  = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_DRIVE;
                    w_vec_next   = 5'd0;
                    w_cnt_next   = 4'd0;
                    w_sig_next   = SEED;
                    w_start_acc  = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                    w_abort_acc  = 1'b1;
                end else if (r_cnt == SETTLE_M1) begin
                    w_state_next = S_CAPTURE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end
            S_CAPTURE: begin
                // abort wins: the partial signature is kept without this vector's response
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_abort_acc  = 1'b1;
                end else begin
                    w_sig_next = misr_step(r_sig, dut_out);
                    if (r_vec == VEC_LAST) begin
                        w_state_next = S_DONE;
                        w_finish     = 1'b1;
                    end else begin
                        w_state_next = S_DRIVE;
                        w_vec_next   = r_vec + 5'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next   = (w_state_next == S_DRIVE) || (w_state_next == S_CAPTURE);
        w_done_next   = (w_state_next == S_DONE);
        if (w_busy_next) begin
            w_dut_in_next = w_vec_next;
        end else begin
            w_dut_in_next = 5'd0;
        end
    end

    assign dut_in = r_dut_in;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sig    = r_sig;

`ifdef CIRCUIT_SWEEP_CMP_EN
    logic r_pass;

    // Golden compare latched on the final capture, cleared on new start or abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if (w_start_acc || w_abort_acc) begin
            r_pass <= 1'b0;
        end else if (w_finish) begin
            r_pass <= (w_sig_next == exp_sig);
        end else begin
            r_pass <= r_pass;
        end
    end

    assign pass = r_pass;
`else
    // Comparator absent: start/abort/finish strobes only steer the FSM.
`endif

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Scoreboard bench for circuit_sweep_ctrl: two instances (SETTLE=1/SEED=0 and SETTLE=2/nonzero SEED).
// Define CIRCUIT_SWEEP_CMP_EN for the bench and RTL together to exercise exp_sig/pass.
module tb_circuit_sweep_ctrl;

    localparam logic [15:0] SEED1 = 16'h0000;
    localparam logic [15:0] SEED2 = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, abort1, start2, abort2;
    logic [4:0]  dut_out1, dut_in1, dut_out2, dut_in2;
    logic        busy1, done1, busy2, done2;
    logic [15:0] sig1, sig2;
`ifdef CIRCUIT_SWEEP_CMP_EN
    logic [15:0] exp_sig1, exp_sig2;
    logic        pass1, pass2;
`endif

    int          mode;
    logic        sel;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    circuit_sweep_ctrl #(.SETTLE(1), .SEED(SEED1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .dut_out(dut_out1), .dut_in(dut_in1), .busy(busy1), .done(done1), .sig(sig1)
`ifdef CIRCUIT_SWEEP_CMP_EN
        , .exp_sig(exp_sig1), .pass(pass1)
`endif
    );

    circuit_sweep_ctrl #(.SETTLE(2), .SEED(SEED2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .dut_out(dut_out2), .dut_in(dut_in2), .busy(busy2), .done(done2), .sig(sig2)
`ifdef CIRCUIT_SWEEP_CMP_EN
        , .exp_sig(exp_sig2), .pass(pass2)
`endif
    );

    // Behavioural stand-in for the circuit under sweep
    function automatic logic [4:0] resp(input int m, input logic [4:0] v);
        logic [4:0] t;
        case (m)
            0:       t = 5'd0;
            1:       t = (v == 5'd30) ? 5'd1 : 5'd0;
            2:       t = (v == 5'd31) ? 5'd1 : 5'd0;
            3:       t = (v * 5'd7) ^ 5'h0B;
            default: t = 5'd0;
        endcase
        return t;
    endfunction

    always_comb dut_out1 = resp(mode, dut_in1);
    always_comb dut_out2 = resp(mode, dut_in2);

    // Reference signature: polynomial x^16 + taps at 15,14,12,3 fed back into bit 0
    function automatic logic [15:0] model_sig(input logic [15:0] seed, input int m, input int nvec);
        logic [15:0] s;
        logic        fb;
        s = seed;
        for (int v = 0; v < nvec; v++) begin
            fb = s[15] ^ s[14] ^ s[12] ^ s[3];
            s  = (s << 1) | {15'd0, fb};
            s  = s ^ {11'd0, resp(m, 5'(v))};
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic s, input logic v);
        start1 = (!s) && v;
        start2 = s && v;
    endtask

    // One full sweep on the selected instance, checked cycle by cycle against the timeline
    task automatic run_sweep(input logic s, input int settle, input bit mid_start);
        int          len;
        logic [15:0] seed;
        logic [15:0] exp_s;
        logic [4:0]  o_in;
        logic        o_busy, o_done;
        logic [15:0] o_sig;
        len  = 32 * (settle + 1);
        seed = s ? SEED2 : SEED1;
        sb_q.push_back(model_sig(seed, mode, 32));
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(s, 1'b0);
        for (int e = 0; e <= len + 1; e++) begin
            o_in   = s ? dut_in2 : dut_in1;
            o_busy = s ? busy2 : busy1;
            o_done = s ? done2 : done1;
            o_sig  = s ? sig2 : sig1;
            set_start(s, mid_start && (e == 7 || e == 30));
            if (e == 0) check("sig_loaded_seed", 32'(o_sig), 32'(seed));
            if (e < len) begin
                check("dut_in_step", 32'(o_in), 32'(e / (settle + 1)));
                check("busy_in_sweep", 32'(o_busy), 32'd1);
                check("no_early_done", 32'(o_done), 32'd0);
            end else if (e == len) begin
                check("done_latency", 32'(o_done), 32'd1);
                check("busy_at_done", 32'(o_busy), 32'd0);
                check("dut_in_at_done", 32'(o_in), 32'd0);
                check("sb_not_empty", 32'(sb_q.size()), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_s = sb_q.pop_front();
                    check("final_sig", 32'(o_sig), 32'(exp_s));
`ifdef CIRCUIT_SWEEP_CMP_EN
                    check("pass_flag", 32'(s ? pass2 : pass1),
                          32'((s ? exp_sig2 : exp_sig1) == exp_s));
`endif
                end
            end else begin
                check("done_one_cycle", 32'(o_done), 32'd0);
                check("idle_after_done", 32'(o_busy), 32'd0);
            end
            @(negedge clk);
        end
        set_start(s, 1'b0);
    endtask

    initial begin
        int  found;
        int  done_cnt;
        rst    = 1'b1;
        start1 = 1'b0; start2 = 1'b0;
        abort1 = 1'b0; abort2 = 1'b0;
        mode   = 0;
        sel    = 1'b0;
`ifdef CIRCUIT_SWEEP_CMP_EN
        exp_sig1 = 16'h0000;
        exp_sig2 = 16'h0000;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_dut_in", 32'(dut_in1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_sig1", 32'(sig1), 32'(SEED1));
        check("rst_sig2", 32'(sig2), 32'(SEED2));
`ifdef CIRCUIT_SWEEP_CMP_EN
        check("rst_pass", 32'(pass1), 32'd0);
`endif
        rst = 1'b0;

        // Zero DUT, then the same sweep against a wrong golden value
        mode = 0;
        run_sweep(1'b0, 1, 1'b0);
        check("zero_sig_const", 32'(sig1), 32'h0000);
`ifdef CIRCUIT_SWEEP_CMP_EN
        exp_sig1 = 16'h0001;
        run_sweep(1'b0, 1, 1'b0);
        check("pass_low_wrong_golden", 32'(pass1), 32'd0);
        exp_sig1 = 16'h0000;
`endif

        // Late single responses
        mode = 1;
        run_sweep(1'b0, 1, 1'b0);
        check("resp_at_30_sig", 32'(sig1), 32'h0002);
        mode = 2;
        run_sweep(1'b0, 1, 1'b0);
        check("resp_at_31_sig", 32'(sig1), 32'h0001);

        // Busy-time start pulses must not disturb the sequence
        mode = 3;
        run_sweep(1'b0, 1, 1'b1);

        // SETTLE=2 instance with nonzero seed
        sel  = 1'b1;
        mode = 0;
        run_sweep(1'b1, 2, 1'b0);
        mode = 3;
        run_sweep(1'b1, 2, 1'b0);
        sel  = 1'b0;

        // Abort at vector 10
        mode = 3;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (dut_in1 == 5'd10) found = 1;
            else @(negedge clk);
        end
        check("abort_reached_vec10", 32'(found), 32'd1);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("abort_busy_low", 32'(busy1), 32'd0);
        check("abort_dut_in_zero", 32'(dut_in1), 32'd0);
        check("abort_partial_sig", 32'(sig1), 32'(model_sig(SEED1, 3, 10)));
`ifdef CIRCUIT_SWEEP_CMP_EN
        check("abort_pass_low", 32'(pass1), 32'd0);
`endif
        done_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            if (done1 || busy1) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_sweep(1'b0, 1, 1'b0);

        // Asynchronous reset mid-sweep at vector 20
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (dut_in1 == 5'd20) found = 1;
            else @(negedge clk);
        end
        check("rst_reached_vec20", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_dut_in", 32'(dut_in1), 32'd0);
        check("arst_busy", 32'(busy1), 32'd0);
        check("arst_done", 32'(done1), 32'd0);
        check("arst_sig", 32'(sig1), 32'(SEED1));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
